tc_rom_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port TC ROM/RAM instance between N_PORTS requesters.
Each requester issues one read or write with a req/ack handshake. The block drives the memory's load, save, address and in, and returns registered read data.
It sits between CPU-side fetch/load-store units and the memory; the memory's rst is tied to the same rst net.

---
 rtl/tc_rom_arbiter_pkg.sv | 35 +++
 rtl/tc_rom_arbiter_if.sv | 30 +++
 rtl/tc_rom_arbiter_picker.sv | 20 ++
 rtl/tc_rom_arbiter.sv | 110 +++++++++++
 tb/tb_tc_rom_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/tc_rom_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the TC ROM/RAM arbiter family.
package tc_rom_arb_pkg;

    localparam int MEM_ADDR_WIDTH = 16;
    localparam int MAX_PORTS      = 8;
    localparam int IDX_W          = 3;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set request at or after ptr, wrapping at n_ports; exclude_idx is skipped when enabled.
    function automatic pick_t rr_pick(input logic [MAX_PORTS-1:0] req_vec,
                                      input logic [IDX_W-1:0]     ptr,
                                      input logic                 exclude_en,
                                      input logic [IDX_W-1:0]     exclude_idx,
                                      input int                   n_ports);
        pick_t            res;
        logic [IDX_W-1:0] cand;
        res = '0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            cand = IDX_W'((int'(ptr) + k) % n_ports);
            if (k < n_ports && !res.found && req_vec[cand] &&
                !(exclude_en && cand == exclude_idx)) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tc_rom_arbiter_if.sv
// Requester and memory-side bundle between the CPU units, the arbiter and the TC memory.
interface tc_rom_arbiter_if
    import tc_rom_arb_pkg::*;
#(
    parameter int N_PORTS    = 2,
    parameter int BIT_WIDTH  = 16,
    parameter int ADDR_WIDTH = 16
);
    logic [N_PORTS-1:0]            req;
    logic [N_PORTS-1:0]            we;
    logic [N_PORTS*ADDR_WIDTH-1:0] addr;
    logic [N_PORTS*BIT_WIDTH-1:0]  wdata;
    logic [N_PORTS-1:0]            ack;
    logic [BIT_WIDTH-1:0]          rdata;
    logic                          mem_load;
    logic                          mem_save;
    logic [MEM_ADDR_WIDTH-1:0]     mem_address;
    logic [BIT_WIDTH-1:0]          mem_in;
    logic [BIT_WIDTH-1:0]          mem_out;

    modport slave (
        input  req, we, addr, wdata, mem_out,
        output ack, rdata, mem_load, mem_save, mem_address, mem_in
    );

    modport master (
        output req, we, addr, wdata, mem_out,
        input  ack, rdata, mem_load, mem_save, mem_address, mem_in
    );
endinterface

// File: rtl/tc_rom_arbiter_picker.sv
// Combinational round-robin priority selector, shared with other single-resource arbiters.
module tc_rr_picker
    import tc_rom_arb_pkg::*;
#(
    parameter int N_PORTS = 2
) (
    input  logic [N_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               excl_en_i,
    input  logic [IDX_W-1:0]   excl_idx_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   idx_o
);
    pick_t pick;

    always_comb pick = rr_pick(MAX_PORTS'(req_i), ptr_i, excl_en_i, excl_idx_i, N_PORTS);

    assign found_o = pick.found;
    assign idx_o   = pick.idx;
endmodule

// File: rtl/tc_rom_arbiter.sv
// Round-robin arbiter sharing one single-port TC memory between N_PORTS req/ack requesters.
module tc_rom_arbiter
    import tc_rom_arb_pkg::*;
#(
    parameter int N_PORTS    = 2,
    parameter int BIT_WIDTH  = 16,
    parameter int ADDR_WIDTH = 16
) (
    input logic              clk,
    input logic              rst,
    tc_rom_arbiter_if.slave  arb
);
    state_e                    state_q;
    logic [IDX_W-1:0]          win_q, rr_q;
    logic                      we_q;
    logic [N_PORTS-1:0]        ack_q;
    logic [BIT_WIDTH-1:0]      rdata_q, mem_in_q;
    logic                      mem_load_q, mem_save_q;
    logic [MEM_ADDR_WIDTH-1:0] mem_address_q;

    logic                      pick_found;
    logic [IDX_W-1:0]          pick_idx;
    logic                      sel_we;
    logic [ADDR_WIDTH-1:0]     sel_addr;
    logic [BIT_WIDTH-1:0]      sel_wdata;

    // In RESP the port being acked may still hold req this cycle, so it is masked out.
    tc_rr_picker #(.N_PORTS(N_PORTS)) u_picker (
        .req_i      (arb.req),
        .ptr_i      (rr_q),
        .excl_en_i  (state_q == RESP),
        .excl_idx_i (win_q),
        .found_o    (pick_found),
        .idx_o      (pick_idx)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_we    = arb.we[i];
                sel_addr  = arb.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = arb.wdata[i*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            win_q         <= '0;
            rr_q          <= '0;
            we_q          <= 1'b0;
            ack_q         <= '0;
            rdata_q       <= '0;
            mem_load_q    <= 1'b0;
            mem_save_q    <= 1'b0;
            mem_address_q <= '0;
            mem_in_q      <= '0;
        end else begin
            case (state_q)
                IDLE, RESP: begin
                    ack_q <= '0;
                    if (pick_found) begin
                        win_q         <= pick_idx;
                        we_q          <= sel_we;
                        mem_address_q <= MEM_ADDR_WIDTH'(sel_addr);
                        mem_in_q      <= sel_wdata;
                        mem_load_q    <= ~sel_we;
                        mem_save_q    <= sel_we;
                        state_q       <= ACCESS;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    // mem_out has settled from the address driven since entry to ACCESS.
                    if (!we_q) rdata_q <= arb.mem_out;
                    for (int i = 0; i < N_PORTS; i++) ack_q[i] <= (win_q == IDX_W'(i));
                    rr_q       <= (win_q == IDX_W'(N_PORTS - 1)) ? '0 : win_q + 1'b1;
                    mem_load_q <= 1'b0;
                    mem_save_q <= 1'b0;
                    state_q    <= RESP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign arb.ack         = ack_q;
    assign arb.rdata       = rdata_q;
    assign arb.mem_load    = mem_load_q;
    assign arb.mem_save    = mem_save_q;
    assign arb.mem_address = mem_address_q;
    assign arb.mem_in      = mem_in_q;

    // Requester protocol checks: once raised, req and its payload hold until the ack cycle.
    for (genvar i = 0; i < N_PORTS; i++) begin : g_proto
        a_req_held: assert property (@(posedge clk) disable iff (rst)
            ($past(arb.req[i]) && !ack_q[i]) |-> arb.req[i])
            else $error("port %0d dropped req before ack", i);
        a_payload_stable: assert property (@(posedge clk) disable iff (rst)
            ($past(arb.req[i]) && !ack_q[i]) |->
                ($stable(arb.we[i]) && $stable(arb.addr[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
                 $stable(arb.wdata[i*BIT_WIDTH +: BIT_WIDTH])))
            else $error("port %0d changed we/addr/wdata before ack", i);
    end
endmodule

// File: tb/tb_tc_rom_arbiter.sv
// Directed and randomized bench for tc_rom_arbiter against a transaction-level arbitration model.
module tb_tc_rom_arbiter;
    localparam int N  = 3;
    localparam int BW = 16;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tc_rom_arbiter_if #(.N_PORTS(N), .BIT_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

    tc_rom_arbiter #(.N_PORTS(N), .BIT_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus)
    );

    function automatic logic [BW-1:0] init_fn(input int a);
        return (a == 5) ? 16'hBEEF : BW'(a * 40503 + 4660);
    endfunction

    // Single-port memory: combinational read, write at negedge.
    logic [BW-1:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_fn(i);
        forever begin
            @(negedge clk);
            if (bus.mem_save) mem[bus.mem_address[7:0]] = bus.mem_in;
        end
    end
    assign bus.mem_out = mem[bus.mem_address[7:0]];

    typedef struct {
        bit            v;
        int            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [BW-1:0] wd;
    } acc_t;

    int            n_cmp = 0, n_err = 0, cyc = 0, save_cnt = 0, mode = 0;
    logic [N-1:0]  pend = '0;
    bit            p_we [N];
    logic [AW-1:0] p_addr [N];
    logic [BW-1:0] p_wd [N];
    logic [BW-1:0] ref_mem [256];
    logic [BW-1:0] exp_rdata;
    acc_t          acc_cur, resp_cur;
    int            rr_m;
    int            ack_log[$];
    int            ack_cyc[$];

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
        end
    endtask

    task automatic issue(input int p, input bit w, input logic [AW-1:0] a, input logic [BW-1:0] d);
        pend[p] = 1'b1; p_we[p] = w; p_addr[p] = a; p_wd[p] = d;
    endtask

    task automatic apply();
        bus.req = pend;
        for (int i = 0; i < N; i++) begin
            bus.we[i]               = p_we[i];
            bus.addr[i*AW +: AW]    = p_addr[i];
            bus.wdata[i*BW +: BW]   = p_wd[i];
        end
    endtask

    task automatic sample_check();
        logic [N-1:0] e_ack;
        e_ack = '0;
        if (resp_cur.v) e_ack[resp_cur.port] = 1'b1;
        chk("ack", bus.ack, e_ack);
        for (int i = 0; i < N; i++) if (bus.ack[i]) begin ack_log.push_back(i); ack_cyc.push_back(cyc); end
        if (bus.mem_save) save_cnt++;
        chk("mem_load", bus.mem_load, acc_cur.v && !acc_cur.we);
        chk("mem_save", bus.mem_save, acc_cur.v && acc_cur.we);
        if (acc_cur.v) begin
            chk("mem_address", bus.mem_address, acc_cur.addr);
            if (acc_cur.we) chk("mem_in", bus.mem_in, acc_cur.wd);
        end
        if (resp_cur.v) begin
            if (resp_cur.we) ref_mem[resp_cur.addr[7:0]] = resp_cur.wd;
            else exp_rdata = ref_mem[resp_cur.addr[7:0]];
        end
        chk("rdata", bus.rdata, exp_rdata);
    endtask

    task automatic requesters();
        if (resp_cur.v) pend[resp_cur.port] = 1'b0;
        for (int i = 0; i < N; i++)
            if (!pend[i] && (mode == 1 || (mode == 2 && $urandom_range(2) == 0)))
                issue(i, bit'($urandom_range(1)), AW'($urandom_range(15)), BW'($urandom));
        apply();
    endtask

    // A grant can be made only when the memory is not mid-access; winner is the first
    // eligible port scanning upward from the rotating pointer.
    task automatic predict();
        acc_t g;
        g.v = 1'b0; g.port = 0; g.we = 1'b0; g.addr = '0; g.wd = '0;
        if (!acc_cur.v) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (rr_m + k) % N;
                if (!g.v && pend[c] && !(resp_cur.v && resp_cur.port == c)) begin
                    g.v = 1'b1; g.port = c; g.we = p_we[c]; g.addr = p_addr[c]; g.wd = p_wd[c];
                end
            end
            if (g.v) rr_m = (g.port + 1) % N;
        end
        resp_cur = acc_cur;
        acc_cur  = g;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        sample_check();
        requesters();
        predict();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            @(negedge clk);
            cyc++;
            chk("rst_ack", bus.ack, 0);
            chk("rst_load", bus.mem_load, 0);
            chk("rst_save", bus.mem_save, 0);
            chk("rst_rdata", bus.rdata, 0);
            chk("rst_addr", bus.mem_address, 0);
            chk("rst_in", bus.mem_in, 0);
        end
        rst = 1'b0;
        acc_cur.v = 1'b0; resp_cur.v = 1'b0; rr_m = 0; exp_rdata = '0;
        predict();
    endtask

    task automatic drain(input string tag, input int bound);
        int k;
        k = 0;
        while (pend != '0 && k < bound) begin step(); k++; end
        chk(tag, pend, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_fn(i);
        acc_cur.v = 1'b0; resp_cur.v = 1'b0;
        for (int i = 0; i < N; i++) issue(i, 1'b0, AW'(i), '0);
        apply();

        // Reset with every port requesting; port 0 must win first.
        do_reset(2);
        drain("reset_drain", 20);
        chk("first_grant", ack_log.size() > 0 ? ack_log[0] : -1, 0);

        // Single read of preloaded data.
        issue(1, 1'b0, 5, '0);
        step();
        step();
        chk("rd_load", bus.mem_load, 1);
        chk("rd_addr", bus.mem_address, 5);
        step();
        chk("rd_ack", bus.ack, 3'b010);
        chk("rd_data", bus.rdata, 16'hBEEF);
        step();

        // Write by port 0, then read of the same address by port 1.
        save_cnt = 0;
        issue(0, 1'b1, 9, 16'h1234);
        drain("wr_drain", 10);
        issue(1, 1'b0, 9, '0);
        drain("rd_drain", 10);
        chk("wr_rd_data", bus.rdata, 16'h1234);
        chk("save_cnt", save_cnt, 1);

        // All ports requesting continuously from a fresh pointer.
        do_reset(1);
        ack_log.delete(); ack_cyc.delete();
        mode = 1;
        for (int k = 0; k < 30 && ack_log.size() < 6; k++) step();
        mode = 0;
        chk("cont_count", ack_log.size() >= 6, 1);
        for (int k = 0; k < 6 && k < ack_log.size(); k++) chk("cont_order", ack_log[k], k % N);
        for (int k = 1; k < 6 && k < ack_cyc.size(); k++) chk("cont_gap", ack_cyc[k] - ack_cyc[k-1], 2);
        drain("cont_drain", 20);

        // Pointer at 2, then ports 0 and 2 request in the same cycle.
        do_reset(1);
        issue(1, 1'b0, 3, '0);
        drain("rr2_drain", 10);
        ack_log.delete();
        issue(0, 1'b0, 4, '0);
        issue(2, 1'b0, 6, '0);
        drain("dbl_drain", 20);
        chk("dbl_first", ack_log.size() > 0 ? ack_log[0] : -1, 2);
        chk("dbl_second", ack_log.size() > 1 ? ack_log[1] : -1, 0);

        // Reset during a port 0 read's ACCESS cycle; the held request completes afterwards.
        ack_log.delete();
        issue(0, 1'b0, 7, '0);
        step();
        step();
        chk("abort_in_access", bus.mem_load, 1);
        do_reset(1);
        drain("abort_drain", 20);
        chk("abort_acks", ack_log.size(), 1);
        chk("abort_port", ack_log.size() > 0 ? ack_log[0] : -1, 0);
        chk("abort_rdata", bus.rdata, init_fn(7));

        // Randomized traffic on a small address window to exercise read-after-write.
        mode = 2;
        repeat (400) step();
        mode = 0;
        drain("rand_drain", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
